// File: rtl/bp_zynq_bedrock_mem_responder.sv
// bp_zynq_bedrock_mem_responder
//   Memory-side end of the BedRock stream channel. It accepts mem_fwd command
//   streams (64-bit beats) and services them against an internal single-port
//   synchronous memory of els_p 64-bit words. It returns mem_rev response
//   streams. It stands in for DRAM in cosim and FPGA bring-up.
//
//   Ports
//     aclk, aresetn        clock, async active-low reset
//     fwd_*                command stream in (v/ready_and/last, header, 64b data)
//     rev_*                response stream out (v/ready_and/last, header, 64b data)
//
//   The word memory is split into NUM_LANES byte-wide banks so that sub-word
//   writes are plain per-lane write enables.

// One byte lane of the word memory: single-port synchronous RAM with a read
// register that only updates on a read access.
module bp_zynq_bedrock_mem_lane #(
  parameter int els_p = 1024,
  parameter int VEC_W = 8
) (
  input  logic                      aclk,
  input  logic                      en,
  input  logic                      we,
  input  logic [$clog2(els_p)-1:0]  idx,
  input  logic [VEC_W-1:0]          wdata,
  output logic [VEC_W-1:0]          rdata
);
  logic [VEC_W-1:0] mem [els_p];

  always_ff @(posedge aclk)
    if (en) begin
      if (we) mem[idx] <= wdata;
      else    rdata    <= mem[idx];
    end
endmodule

module bp_zynq_bedrock_mem_responder #(
  parameter int paddr_width_p   = 34,
  parameter int block_width_p   = 256,
  parameter int payload_width_p = 16,
  parameter int els_p           = 1024
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       fwd_v_i,
  output logic                       fwd_ready_and_o,
  input  logic                       fwd_last_i,
  input  logic [1:0]                 fwd_opcode_i,
  input  logic [paddr_width_p-1:0]   fwd_addr_i,
  input  logic [2:0]                 fwd_size_i,
  input  logic [payload_width_p-1:0] fwd_payload_i,
  input  logic [63:0]                fwd_data_i,
  output logic                       rev_v_o,
  input  logic                       rev_ready_and_i,
  output logic                       rev_last_o,
  output logic [1:0]                 rev_opcode_o,
  output logic [paddr_width_p-1:0]   rev_addr_o,
  output logic [2:0]                 rev_size_o,
  output logic [payload_width_p-1:0] rev_payload_o,
  output logic [63:0]                rev_data_o
);
  localparam int NUM_LANES   = 8;
  localparam int VEC_W       = 8;
  localparam int lg_els_lp   = $clog2(els_p);
  localparam int max_size_lp = $clog2(block_width_p/8);
  localparam int lg_beats_lp = $clog2(block_width_p/64);
  localparam int kw_lp       = (lg_beats_lp > 0) ? lg_beats_lp : 1;

  typedef struct packed {
    logic [1:0]                 opcode;
    logic [paddr_width_p-1:0]   addr;
    logic [2:0]                 size;
    logic [payload_width_p-1:0] payload;
  } hdr_t;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

  // Sizes beyond one cache block are treated as a full block.
  function automatic logic [2:0] eff_size(input logic [2:0] s);
    return (s > 3'(max_size_lp)) ? 3'(max_size_lp) : s;
  endfunction

  // Beat count minus one; doubles as the wrap mask for the beat index.
  function automatic logic [kw_lp-1:0] last_k(input logic [2:0] s);
    logic [2:0] e;
    e = eff_size(s);
    return (e > 3'd3) ? kw_lp'((1 << (e - 3'd3)) - 1) : '0;
  endfunction

  // Critical-word-first index: low bits wrap inside the aligned block.
  function automatic logic [lg_els_lp-1:0] word_idx(input logic [paddr_width_p-1:0] a,
                                                    input logic [2:0] s,
                                                    input logic [kw_lp-1:0] k);
    logic [lg_els_lp-1:0] base, m;
    base = a[3 +: lg_els_lp];
    m    = lg_els_lp'(last_k(s));
    return (base & ~m) | ((base + lg_els_lp'(k)) & m);
  endfunction

  function automatic logic [NUM_LANES-1:0] byte_mask(input logic [paddr_width_p-1:0] a,
                                                     input logic [2:0] s);
    logic [2:0] e;
    logic [NUM_LANES-1:0] m;
    e = eff_size(s);
    if (e >= 3'd3) m = '1;
    else           m = NUM_LANES'((1 << (1 << e)) - 1) << a[2:0];
    return m;
  endfunction

  // Sub-word data arrives in the low bytes; move it to its byte lanes.
  function automatic logic [63:0] wr_fmt(input logic [63:0] d,
                                         input logic [paddr_width_p-1:0] a,
                                         input logic [2:0] s);
    return (eff_size(s) >= 3'd3) ? d : (d << {a[2:0], 3'b000});
  endfunction

  // Sub-word reads are aligned down and replicated across the word.
  function automatic logic [63:0] rd_fmt(input logic [63:0] w,
                                         input logic [paddr_width_p-1:0] a,
                                         input logic [2:0] s);
    logic [63:0] sh;
    sh = w >> {a[2:0], 3'b000};
    case (eff_size(s))
      3'd0:    return {8{sh[7:0]}};
      3'd1:    return {4{sh[15:0]}};
      3'd2:    return {2{sh[31:0]}};
      default: return w;
    endcase
  endfunction

  state_e           state;
  hdr_t             hdr;
  logic [kw_lp-1:0] k;
  logic             fwd_ready_r, rev_v_r, rev_last_r;

  logic fwd_hs, rev_hs;
  assign fwd_hs = fwd_v_i & fwd_ready_and_o;
  assign rev_hs = rev_v_o & rev_ready_and_i;

  logic                                mem_en, mem_we;
  logic [lg_els_lp-1:0]                mem_idx;
  logic [NUM_LANES-1:0]                mem_mask;
  logic [NUM_LANES-1:0][VEC_W-1:0]     mem_wdata, mem_rdata;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = '0;
    mem_mask  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: if (fwd_hs) begin
        mem_en    = 1'b1;
        mem_we    = fwd_opcode_i[0];
        mem_idx   = word_idx(fwd_addr_i, fwd_size_i, '0);
        mem_mask  = byte_mask(fwd_addr_i, fwd_size_i);
        mem_wdata = wr_fmt(fwd_data_i, fwd_addr_i, fwd_size_i);
      end
      WDATA: if (fwd_hs) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_idx   = word_idx(hdr.addr, hdr.size, k);
        mem_mask  = byte_mask(hdr.addr, hdr.size);
        mem_wdata = wr_fmt(fwd_data_i, hdr.addr, hdr.size);
      end
      // Prefetch the next beat on the accepting edge so beats stream without
      // bubbles; while stalled no read is issued and the RAM output holds.
      RDATA: if (rev_hs && k != last_k(hdr.size)) begin
        mem_en  = 1'b1;
        mem_idx = word_idx(hdr.addr, hdr.size, k + 1'b1);
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    bp_zynq_bedrock_mem_lane #(.els_p(els_p), .VEC_W(VEC_W)) lane (
      .aclk  (aclk),
      .en    (mem_en),
      .we    (mem_we & mem_mask[i]),
      .idx   (mem_idx),
      .wdata (mem_wdata[i]),
      .rdata (mem_rdata[i])
    );
  end

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state       <= IDLE;
      hdr         <= '0;
      k           <= '0;
      fwd_ready_r <= 1'b0;
      rev_v_r     <= 1'b0;
      rev_last_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fwd_ready_r <= 1'b1;
          if (fwd_hs) begin
            hdr.opcode  <= fwd_opcode_i;
            hdr.addr    <= fwd_addr_i;
            hdr.size    <= fwd_size_i;
            hdr.payload <= fwd_payload_i;
            k           <= '0;
            if (fwd_opcode_i[0]) begin
              if (fwd_last_i) begin
                state       <= WRESP;
                fwd_ready_r <= 1'b0;
                rev_v_r     <= 1'b1;
                rev_last_r  <= 1'b1;
              end else begin
                state <= WDATA;
                k     <= kw_lp'(1) & last_k(fwd_size_i);
              end
            end else begin
              state       <= RDATA;
              fwd_ready_r <= 1'b0;
              rev_v_r     <= 1'b1;
              rev_last_r  <= (last_k(fwd_size_i) == '0);
            end
          end
        end
        WDATA: if (fwd_hs) begin
          k <= (k + 1'b1) & last_k(hdr.size);
          // last ends the message even if fewer than N beats were sent
          if (fwd_last_i) begin
            state       <= WRESP;
            fwd_ready_r <= 1'b0;
            rev_v_r     <= 1'b1;
            rev_last_r  <= 1'b1;
          end
        end
        WRESP: if (rev_hs) begin
          state       <= IDLE;
          fwd_ready_r <= 1'b1;
          rev_v_r     <= 1'b0;
          rev_last_r  <= 1'b0;
        end
        RDATA: if (rev_hs) begin
          if (k == last_k(hdr.size)) begin
            state       <= IDLE;
            fwd_ready_r <= 1'b1;
            rev_v_r     <= 1'b0;
            rev_last_r  <= 1'b0;
          end else begin
            k          <= k + 1'b1;
            rev_last_r <= ((k + 1'b1) == last_k(hdr.size));
          end
        end
        default: state <= IDLE;
      endcase
    end

  assign fwd_ready_and_o = fwd_ready_r;
  assign rev_v_o         = rev_v_r;
  assign rev_last_o      = rev_last_r;
  assign rev_opcode_o    = hdr.opcode;
  assign rev_addr_o      = hdr.addr;
  assign rev_size_o      = hdr.size;
  assign rev_payload_o   = hdr.payload;
  assign rev_data_o      = (state == RDATA) ? rd_fmt(mem_rdata, hdr.addr, hdr.size) : '0;
endmodule

// File: tb/tb_bp_zynq_bedrock_mem_responder.sv
module tb_bp_zynq_bedrock_mem_responder;
  logic        aclk = 1'b0, aresetn = 1'b0;
  logic        fwd_v = 1'b0, fwd_rdy, fwd_last = 1'b0;
  logic [1:0]  fwd_op = '0;
  logic [33:0] fwd_addr = '0;
  logic [2:0]  fwd_size = '0;
  logic [15:0] fwd_pl = '0;
  logic [63:0] fwd_data = '0;
  logic        rev_v, rev_ready = 1'b0, rev_last;
  logic [1:0]  rev_op;
  logic [33:0] rev_addr;
  logic [2:0]  rev_size;
  logic [15:0] rev_pl;
  logic [63:0] rev_data;

  bp_zynq_bedrock_mem_responder dut (
    .aclk(aclk), .aresetn(aresetn),
    .fwd_v_i(fwd_v), .fwd_ready_and_o(fwd_rdy), .fwd_last_i(fwd_last),
    .fwd_opcode_i(fwd_op), .fwd_addr_i(fwd_addr), .fwd_size_i(fwd_size),
    .fwd_payload_i(fwd_pl), .fwd_data_i(fwd_data),
    .rev_v_o(rev_v), .rev_ready_and_i(rev_ready), .rev_last_o(rev_last),
    .rev_opcode_o(rev_op), .rev_addr_o(rev_addr), .rev_size_o(rev_size),
    .rev_payload_o(rev_pl), .rev_data_o(rev_data)
  );

  always #5 aclk = ~aclk;

  int checks = 0, errors = 0;

  // reference model: word memory plus the addressing rules in plain arithmetic
  logic [63:0] mw [0:1023];
  logic [63:0] beat_q[$];
  logic [63:0] r_data[$];
  logic        r_last[$];
  logic [1:0]  r_op[$];
  logic [33:0] r_addr[$];
  logic [2:0]  r_size[$];
  logic [15:0] r_pl[$];
  int r_bubbles, r_fwdrdy, r_stall_bad, r_tmo, s_tmo;
  logic r_v0;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic int m_eff(input logic [2:0] s);
    return (s > 3'd5) ? 5 : int'(s);
  endfunction

  function automatic int m_n(input logic [2:0] s);
    return (m_eff(s) > 3) ? (1 << (m_eff(s) - 3)) : 1;
  endfunction

  function automatic int m_idx(input logic [33:0] a, input logic [2:0] s, input int k);
    int n, base;
    n    = m_n(s);
    base = int'((a >> 3) % 1024);
    return (base / n) * n + ((base % n + k) % n);
  endfunction

  function automatic void m_write(input logic [33:0] a, input logic [2:0] s, input int k,
                                  input logic [63:0] d);
    int idx, off;
    idx = m_idx(a, s, k);
    off = int'(a % 8);
    if (m_eff(s) >= 3) mw[idx] = d;
    else for (int i = 0; i < (1 << m_eff(s)); i++) mw[idx][8*(off+i) +: 8] = d[8*i +: 8];
  endfunction

  function automatic logic [63:0] m_read(input logic [33:0] a, input logic [2:0] s, input int k);
    logic [63:0] w, r;
    int nb, off;
    w = mw[m_idx(a, s, k)];
    if (m_eff(s) >= 3) return w;
    nb = 1 << m_eff(s);
    off = int'(a % 8);
    for (int i = 0; i < 8; i++) r[8*i +: 8] = w[8*(off + (i % nb)) +: 8];
    return r;
  endfunction

  // drive the beats in beat_q as one command, last on the final beat
  task automatic send_cmd(input logic [1:0] op, input logic [33:0] a, input logic [2:0] s,
                          input logic [15:0] pl);
    int cyc;
    s_tmo = 0;
    for (int b = 0; b < beat_q.size(); b++) begin
      @(negedge aclk);
      fwd_v = 1'b1; fwd_op = op; fwd_addr = a; fwd_size = s; fwd_pl = pl;
      fwd_data = beat_q[b]; fwd_last = (b == beat_q.size() - 1);
      cyc = 0;
      while (!fwd_rdy && cyc < 50) begin @(negedge aclk); cyc++; end
      if (cyc >= 50) s_tmo = 1;
      @(posedge aclk);
    end
    @(negedge aclk);
    fwd_v = 1'b0; fwd_last = 1'b0;
  endtask

  // collect one response; mode 0 always ready, 1 stall 3 cycles on beat stall_at, 2 random
  task automatic recv(input int mode, input int stall_at);
    int cyc, stall;
    logic [63:0] sd;
    logic sl;
    bit done;
    cyc = 0; stall = 0; done = 0; sd = '0; sl = 1'b0;
    r_data.delete(); r_last.delete(); r_op.delete(); r_addr.delete(); r_size.delete(); r_pl.delete();
    r_bubbles = 0; r_fwdrdy = 0; r_stall_bad = 0; r_tmo = 0;
    r_v0 = rev_v;
    while (!done) begin
      if (mode == 1 && r_data.size() == stall_at && stall < 3) begin
        rev_ready = 1'b0;
        if (stall == 0) begin sd = rev_data; sl = rev_last; end
        if (rev_v !== 1'b1 || rev_data !== sd || rev_last !== sl) r_stall_bad++;
        stall++;
      end else if (mode == 2) rev_ready = ($urandom_range(0, 3) != 0);
      else rev_ready = 1'b1;
      if (fwd_rdy) r_fwdrdy++;
      if (rev_ready && !rev_v) r_bubbles++;
      if (rev_ready && rev_v) begin
        if (mode == 1 && r_data.size() == stall_at && (rev_data !== sd || rev_last !== sl)) r_stall_bad++;
        r_data.push_back(rev_data); r_last.push_back(rev_last); r_op.push_back(rev_op);
        r_addr.push_back(rev_addr); r_size.push_back(rev_size); r_pl.push_back(rev_pl);
        if (rev_last) done = 1;
      end
      @(posedge aclk); @(negedge aclk);
      cyc++;
      if (cyc > 60 && !done) begin r_tmo = 1; done = 1; end
    end
    rev_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (fwd_rdy !== 1'b0) begin errors++; $display("FAIL reset_fwd_ready got %b exp 0", fwd_rdy); end
    checks++; if (rev_v !== 1'b0 || rev_last !== 1'b0) begin errors++; $display("FAIL reset_rev_v got v=%b last=%b exp 0", rev_v, rev_last); end
    checks++; if (rev_addr !== '0 || rev_pl !== '0) begin errors++; $display("FAIL reset_hdr got addr=%h pl=%h exp 0", rev_addr, rev_pl); end
    @(negedge aclk); aresetn = 1'b1;
    @(negedge aclk);
    checks++; if (fwd_rdy !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", fwd_rdy); end
  endtask

  task automatic test_write_read();
    beat_q = {64'hDEADBEEF_01234567};
    send_cmd(2'd1, 34'h100, 3'd3, 16'h5A); recv(0, 0);
    m_write(34'h100, 3'd3, 0, 64'hDEADBEEF_01234567);
    checks++; if (s_tmo || r_tmo || r_data.size() != 1) begin errors++; $display("FAIL wr8_ack_count got %0d exp 1 tmo=%0d/%0d", r_data.size(), s_tmo, r_tmo); end
    else begin
      checks++; if (r_v0 !== 1'b1) begin errors++; $display("FAIL wr8_latency got v=%b exp 1", r_v0); end
      checks++; if (r_last[0] !== 1'b1 || r_data[0] !== '0 || r_pl[0] !== 16'h5A || r_op[0] !== 2'd1)
        begin errors++; $display("FAIL wr8_ack got last=%b data=%h pl=%h op=%0d exp 1/0/5a/1", r_last[0], r_data[0], r_pl[0], r_op[0]); end
    end
    beat_q = {64'h0};
    send_cmd(2'd0, 34'h100, 3'd3, 16'h77); recv(0, 0);
    checks++; if (s_tmo || r_tmo || r_data.size() != 1) begin errors++; $display("FAIL rd8_count got %0d exp 1", r_data.size()); end
    else begin
      checks++; if (r_v0 !== 1'b1) begin errors++; $display("FAIL rd8_latency got v=%b exp 1", r_v0); end
      checks++; if (r_data[0] !== 64'hDEADBEEF_01234567 || r_last[0] !== 1'b1 || r_addr[0] !== 34'h100)
        begin errors++; $display("FAIL rd8_data got %h last=%b addr=%h exp deadbeef01234567/1/100", r_data[0], r_last[0], r_addr[0]); end
    end
  endtask

  task automatic test_block_cwf();
    logic [63:0] bv [4];
    logic [63:0] exp [4];
    for (int i = 0; i < 4; i++) bv[i] = rnd64();
    beat_q = {bv[0], bv[1], bv[2], bv[3]};
    send_cmd(2'd1, 34'h200, 3'd5, 16'h1); recv(0, 0);
    checks++; if (s_tmo || r_tmo || r_data.size() != 1 || r_last[0] !== 1'b1) begin errors++; $display("FAIL blk_wr_ack got n=%0d exp 1", r_data.size()); end
    for (int i = 0; i < 4; i++) m_write(34'h200, 3'd5, i, bv[i]);
    exp = '{bv[2], bv[3], bv[0], bv[1]};
    beat_q = {64'h0};
    send_cmd(2'd0, 34'h210, 3'd5, 16'h2); recv(0, 0);
    checks++; if (s_tmo || r_tmo || r_data.size() != 4) begin errors++; $display("FAIL cwf_count got %0d exp 4", r_data.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= r_data.size() || r_data[i] !== exp[i] || r_last[i] !== (i == 3))
        begin errors++; $display("FAIL cwf_beat%0d got %h exp %h", i, (i < r_data.size()) ? r_data[i] : 64'h0, exp[i]); end
    end
    checks++; if (r_bubbles != 0 || r_fwdrdy != 0 || r_v0 !== 1'b1) begin errors++; $display("FAIL cwf_stream got bubbles=%0d fwdrdy=%0d v0=%b exp 0/0/1", r_bubbles, r_fwdrdy, r_v0); end
  endtask

  task automatic test_subword();
    beat_q = {64'h88776655_44332211};
    send_cmd(2'd1, 34'h300, 3'd3, 16'h3); recv(0, 0);
    m_write(34'h300, 3'd3, 0, 64'h88776655_44332211);
    beat_q = {64'hAAAA};
    send_cmd(2'd3, 34'h302, 3'd1, 16'h4); recv(0, 0);
    m_write(34'h302, 3'd1, 0, 64'hAAAA);
    checks++; if (s_tmo || r_tmo || r_data.size() != 1 || r_data[0] !== '0 || r_op[0] !== 2'd3) begin errors++; $display("FAIL sub_wr_ack got n=%0d exp 1 uc_wr ack", r_data.size()); end
    beat_q = {64'h0};
    send_cmd(2'd0, 34'h300, 3'd3, 16'h5); recv(0, 0);
    checks++; if (r_data.size() != 1 || r_data[0] !== 64'h88776655_AAAA2211) begin errors++; $display("FAIL sub_merge got %h exp 88776655aaaa2211", (r_data.size() > 0) ? r_data[0] : 64'h0); end
    send_cmd(2'd2, 34'h302, 3'd1, 16'h6); recv(0, 0);
    checks++; if (r_data.size() != 1 || r_data[0] !== 64'hAAAAAAAA_AAAAAAAA) begin errors++; $display("FAIL sub_repl got %h exp aaaaaaaaaaaaaaaa", (r_data.size() > 0) ? r_data[0] : 64'h0); end
  endtask

  task automatic test_backpressure();
    beat_q = {rnd64(), rnd64(), rnd64(), rnd64()};
    for (int i = 0; i < 4; i++) m_write(34'h400, 3'd5, i, beat_q[i]);
    send_cmd(2'd1, 34'h400, 3'd5, 16'h7); recv(0, 0);
    beat_q = {64'h0};
    send_cmd(2'd0, 34'h408, 3'd5, 16'h8); recv(1, 2);
    checks++; if (s_tmo || r_tmo || r_data.size() != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", r_data.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= r_data.size() || r_data[i] !== m_read(34'h408, 3'd5, i) || r_last[i] !== (i == 3))
        begin errors++; $display("FAIL bp_beat%0d got %h exp %h", i, (i < r_data.size()) ? r_data[i] : 64'h0, m_read(34'h408, 3'd5, i)); end
    end
    checks++; if (r_stall_bad != 0 || r_fwdrdy != 0) begin errors++; $display("FAIL bp_hold got unstable=%0d fwdrdy=%0d exp 0/0", r_stall_bad, r_fwdrdy); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] e0, e1;
    int vcnt;
    e0 = rnd64(); e1 = rnd64();
    @(negedge aclk);
    fwd_v = 1'b1; fwd_op = 2'd1; fwd_addr = 34'h500; fwd_size = 3'd5; fwd_pl = 16'h11;
    fwd_last = 1'b0; fwd_data = e0;
    @(posedge aclk); @(negedge aclk);
    fwd_data = e1;
    checks++; if (fwd_rdy !== 1'b1) begin errors++; $display("FAIL mid_wdata_ready got %b exp 1", fwd_rdy); end
    @(posedge aclk); @(negedge aclk);
    m_write(34'h500, 3'd5, 0, e0); m_write(34'h500, 3'd5, 1, e1);
    fwd_v = 1'b0;
    aresetn = 1'b0;
    #1;
    checks++; if (fwd_rdy !== 1'b0 || rev_v !== 1'b0) begin errors++; $display("FAIL mid_reset_drop got rdy=%b v=%b exp 0/0", fwd_rdy, rev_v); end
    @(negedge aclk); aresetn = 1'b1;
    @(negedge aclk);
    checks++; if (fwd_rdy !== 1'b1) begin errors++; $display("FAIL mid_reset_idle got rdy=%b exp 1", fwd_rdy); end
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin if (rev_v) vcnt++; @(negedge aclk); end
    checks++; if (vcnt != 0) begin errors++; $display("FAIL mid_stale_ack got %0d valid cycles exp 0", vcnt); end
  endtask

  task automatic test_early_last();
    int vcnt;
    beat_q = {rnd64(), rnd64(), rnd64(), rnd64()};
    for (int i = 0; i < 4; i++) m_write(34'h600, 3'd5, i, beat_q[i]);
    send_cmd(2'd1, 34'h600, 3'd5, 16'h9); recv(0, 0);
    beat_q = {rnd64(), rnd64()};
    for (int i = 0; i < 2; i++) m_write(34'h600, 3'd5, i, beat_q[i]);
    send_cmd(2'd1, 34'h600, 3'd5, 16'hA); recv(0, 0);
    checks++; if (s_tmo || r_tmo || r_data.size() != 1 || r_v0 !== 1'b1) begin errors++; $display("FAIL early_last_ack got n=%0d v0=%b exp 1/1", r_data.size(), r_v0); end
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin if (rev_v) vcnt++; @(negedge aclk); end
    checks++; if (vcnt != 0) begin errors++; $display("FAIL early_last_extra got %0d exp 0", vcnt); end
    beat_q = {64'h0};
    send_cmd(2'd0, 34'h600, 3'd7, 16'hB); recv(0, 0);
    checks++; if (s_tmo || r_tmo || r_data.size() != 4 || r_size[0] !== 3'd7) begin errors++; $display("FAIL oversize_count got %0d exp 4", r_data.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= r_data.size() || r_data[i] !== m_read(34'h600, 3'd7, i) || r_last[i] !== (i == 3))
        begin errors++; $display("FAIL oversize_beat%0d got %h exp %h", i, (i < r_data.size()) ? r_data[i] : 64'h0, m_read(34'h600, 3'd7, i)); end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [2:0] sz;
    logic [33:0] a;
    logic [15:0] pl;
    int n, al;
    for (int b = 0; b < 16; b++) begin
      a = 34'h800 + 34'(b * 32);
      beat_q = {rnd64(), rnd64(), rnd64(), rnd64()};
      for (int i = 0; i < 4; i++) m_write(a, 3'd5, i, beat_q[i]);
      send_cmd(2'd1, a, 3'd5, 16'h0); recv(0, 0);
    end
    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom_range(0, 3));
      sz = 3'($urandom_range(0, 7));
      al = (m_eff(sz) < 3) ? (1 << m_eff(sz)) : 8;
      a  = 34'h800 + 34'($urandom_range(0, 511) & ~(al - 1));
      pl = 16'($urandom);
      n  = m_n(sz);
      beat_q.delete();
      if (op[0]) begin
        for (int i = 0; i < n; i++) beat_q.push_back(rnd64());
        for (int i = 0; i < n; i++) m_write(a, sz, i, beat_q[i]);
        send_cmd(op, a, sz, pl); recv(2, 0);
        checks++;
        if (s_tmo || r_tmo || r_data.size() != 1 || r_data[0] !== '0 || r_last[0] !== 1'b1 || r_v0 !== 1'b1)
          begin errors++; $display("FAIL rnd%0d_wr_ack got n=%0d tmo=%0d/%0d", t, r_data.size(), s_tmo, r_tmo); end
      end else begin
        beat_q.push_back(64'h0);
        send_cmd(op, a, sz, pl); recv(2, 0);
        checks++;
        if (s_tmo || r_tmo || r_data.size() != n || r_v0 !== 1'b1 || r_fwdrdy != 0)
          begin errors++; $display("FAIL rnd%0d_rd_count got %0d exp %0d", t, r_data.size(), n); end
        for (int i = 0; i < n; i++) begin
          checks++;
          if (i >= r_data.size() || r_data[i] !== m_read(a, sz, i) || r_last[i] !== (i == n - 1))
            begin errors++; $display("FAIL rnd%0d_beat%0d addr %h size %0d got %h exp %h", t, i, a, sz,
                                     (i < r_data.size()) ? r_data[i] : 64'h0, m_read(a, sz, i)); end
        end
      end
      checks++;
      if (r_data.size() == 0 || r_op[0] !== op || r_addr[0] !== a || r_size[0] !== sz || r_pl[0] !== pl)
        begin errors++; $display("FAIL rnd%0d_hdr got op=%0d addr=%h size=%0d pl=%h exp %0d/%h/%0d/%h", t,
                                 (r_op.size() > 0) ? r_op[0] : 2'd0, (r_addr.size() > 0) ? r_addr[0] : 34'h0,
                                 (r_size.size() > 0) ? r_size[0] : 3'd0, (r_pl.size() > 0) ? r_pl[0] : 16'h0, op, a, sz, pl); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_block_cwf();
    test_subword();
    test_backpressure();
    test_reset_mid();
    test_early_last();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bp_zynq_bedrock_mem_responder.md
Name: bp_zynq_bedrock_mem_responder

Overview:
- BedRock stream memory responder: the memory-side end of the BedRock memory channel.
- Accepts mem_fwd command streams from a BP core or L2 at 64-bit fill width, services them against an internal single-port synchronous 64-bit word memory, and returns mem_rev response streams.
- Used as the backing memory for unicore and multicore cosim and FPGA bring-up in place of the DRAM path.

Parameters:
- paddr_width_p, 34: physical address width.
- block_width_p, 256: cache block width in bits; fixes the maximum beats per message (block_width_p/64 = 4).
- payload_width_p, 16: opaque payload bits echoed from command to response.
- els_p, 1024: number of 64-bit words in the memory; must be a power of two.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- fwd_v_i  in  1  command beat valid
- fwd_ready_and_o  out  1  command beat ready
- fwd_last_i  in  1  final beat of the command
- fwd_opcode_i  in  2  0=rd, 1=wr, 2=uc_rd, 3=uc_wr
- fwd_addr_i  in  paddr_width_p  byte address (critical-word first); held constant across all beats
- fwd_size_i  in  3  log2 bytes (0..5); held across all beats
- fwd_payload_i  in  payload_width_p  echoed; held across all beats
- fwd_data_i  in  64  write data beat
- rev_v_o  out  1  response beat valid
- rev_ready_and_i  in  1  response beat ready
- rev_last_o  out  1  final response beat
- rev_opcode_o  out  2  copy of the command opcode
- rev_addr_o  out  paddr_width_p  copy of the command address
- rev_size_o  out  3  copy of the command size
- rev_payload_o  out  payload_width_p  copy of the command payload
- rev_data_o  out  64  read data; 0 for write acks

Behaviour:
- Reset (async, aresetn=0):
  - State is IDLE, beat counter is 0, latched header is 0.
  - rev_v_o=0, rev_last_o=0, fwd_ready_and_o=0 while in reset.
  - Memory contents are not reset.
  - Reset asserted mid-message drops the message; no partial response is emitted after release.
- Handshake: a beat transfers on v & ready_and. After fwd_ready_and_o=1 is asserted it does not depend on fwd_v_i. rev_v_o does not depend on rev_ready_and_i.
- Sizes:
  - Effective size = min(size, log2(block_width_p/8)); sizes above 5 are clamped to the block size.
  - Beats N = max(1, 2^size/8).
- Word index for beat k:
  - base = addr[3 +: lg(els_p)]
  - With lb = lg(N), the low lb bits of the index are (base[lb-1:0] + k) mod N; the upper bits are taken from base.
  - Addresses therefore wrap within the aligned block.
- Sub-word (size < 3):
  - Write mask covers 2^size bytes starting at addr[2:0].
  - Read data = (word >> 8*addr[2:0]) with the low 2^size bytes replicated across all 64 bits.
  - uc_* opcodes behave identically to rd/wr.
- FSM states:
  - IDLE:
    - fwd_ready_and_o=1.
    - On a handshake, latch opcode, addr, size and payload, and set k=0.
    - Write: write beat 0 this cycle. If fwd_last_i, go to WRESP; otherwise go to WDATA with k=1.
    - Read: issue the memory read for beat 0 and go to RDATA.
  - WDATA:
    - fwd_ready_and_o=1.
    - Each handshake writes beat k and increments k mod N.
    - fwd_last_i goes to WRESP. It terminates the message even if fewer than N beats were sent.
    - Extra beats beyond N wrap k.
  - WRESP:
    - rev_v_o=1, rev_last_o=1, rev_data_o=0; single beat.
    - Handshake goes to IDLE.
  - RDATA:
    - rev_v_o=1 and rev_data_o = memory output for beat k; rev_last_o = (k==N-1).
    - Under stall, data and valid hold. No read is issued while stalled; memory output is stable.
    - On handshake with k<N-1: issue the read for k+1 in the same cycle and increment k; the next beat is valid the following cycle with no bubble.
    - On handshake with k==N-1: go to IDLE.
- Latency:
  - Read command accepted at cycle t gives rev beat 0 valid at t+1.
  - Last write beat accepted at t gives the ack valid at t+1.
  - Next command is accepted no earlier than the cycle after the final rev handshake.
- Response fields: rev_opcode_o, rev_addr_o, rev_size_o and rev_payload_o come from the latched header and are stable for the whole response.

Test Plan:
- Write then read, 8 bytes:
  - Stimulus: wr addr 0x100, size 3, data 0xDEADBEEF_01234567, payload 0x5A; then rd addr 0x100, size 3.
  - Response: the ack has last=1, data 0, payload 0x5A. The read beat returns 0xDEADBEEF_01234567 one cycle after acceptance.
- Block write and critical-word-first read:
  - Stimulus: wr addr 0x200, size 5, beats A, B, C, D; then rd addr 0x210, size 5.
  - Response: beats C, D, A, B; last on the 4th beat; no bubbles with rev_ready_and_i held at 1.
- Sub-word access:
  - Stimulus: after filling 0x300 with 0x8877665544332211, wr addr 0x302, size 1, data 0xAAAA; then rd addr 0x300, size 3.
  - Response: 0x88776655AAAA2211. A further rd addr 0x302, size 1 returns 0xAAAAAAAAAAAAAAAA.
- Backpressure:
  - Stimulus: during a 4-beat read, drop rev_ready_and_i for 3 cycles on beat 2.
  - Response: beat 2 data, valid and last stay stable; fwd_ready_and_o=0 throughout; the order is unaltered.
- Reset mid-operation:
  - Stimulus: assert aresetn=0 after 2 of 4 write beats.
  - Response: rev_v_o and fwd_ready_and_o drop immediately. After release, fwd_ready_and_o=1 in IDLE and no stale ack appears.
- Early last and oversize:
  - Stimulus: wr size 5 with fwd_last_i on beat 2; separately rd size 7.
  - Response: a single ack after beat 2; the size-7 read returns 4 beats (clamped).
